// File: rtl/onewire_pkg.sv
// rtl/onewire_pkg.sv - shared state type, slot multipliers and counter sizing for the 1-wire slave
package onewire_pkg;

  typedef enum logic [2:0] {IDLE, SLOT, HOLD, RSTL, PWAIT, PRES} ow_state_e;

  localparam int RST_SLOTS   = 8;
  localparam int PWAIT_SLOTS = 1;
  localparam int PRES_SLOTS  = 4;

  // Sized for the longest interval timed: a reset detect in normal mode.
  function automatic int cnt_width(input int tsn);
    return $clog2(RST_SLOTS * tsn + 1);
  endfunction

endpackage

// File: rtl/onewire_sync.sv
// rtl/onewire_sync.sv - pad synchroniser with fall/rise strobes on the synchronised level
module onewire_sync #(
  parameter int SYN = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic owr_i,
  output logic owr_s,
  output logic fall,
  output logic rise
);

  logic [SYN-1:0] sync_q, sync_d;
  logic           last_q, last_d;

  always_comb begin
    sync_d = {sync_q[SYN-2:0], owr_i};
    last_d = sync_q[SYN-1];
  end

  // The idle bus is pulled high, so the chain resets to ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      last_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      last_q <= last_d;
    end
  end

  assign owr_s = sync_q[SYN-1];
  assign fall  = last_q & ~owr_s;
  assign rise  = ~last_q & owr_s;

endmodule

// File: rtl/onewire_slave_sync.sv
// rtl/onewire_slave_sync.sv - clocked 1-wire slave: reset/presence, bit slots, word packing
module onewire_slave_sync
  import onewire_pkg::*;
#(
  parameter int TSN = 30,
  parameter int TSO = 4,
  parameter int BDW = 8,
  parameter int SYN = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ena,
  input  logic           ovd,
  input  logic           owr_i,
  output logic           owr_e,
  input  logic [BDW-1:0] tx_dat,
  input  logic           tx_vld,
  output logic           tx_rdy,
  output logic [BDW-1:0] rx_dat,
  output logic           rx_vld,
  output logic           rst_det,
  output logic           busy
);

  localparam int CW  = cnt_width(TSN);
  localparam int BCW = $clog2(BDW + 1);

  ow_state_e      state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [BCW-1:0] bit_cnt_q, bit_cnt_d;
  logic [BDW-1:0] rx_sh_q, rx_sh_d, tx_sh_q, tx_sh_d;
  logic [BDW-1:0] buf_q, buf_d, rx_dat_q, rx_dat_d;
  logic           owr_e_q, owr_e_d, ovd_q, ovd_d, rxbit_q, rxbit_d;
  logic           buf_full_q, buf_full_d, rx_vld_q, rx_vld_d, rst_det_q, rst_det_d;
  logic           owr_s, fall, rise;
  logic [CW-1:0]  t_last, t_rst, t_pw, t_pres;

  onewire_sync #(.SYN(SYN)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .owr_i (owr_i),
    .owr_s (owr_s),
    .fall  (fall),
    .rise  (rise)
  );

  // Terminal counts for the slot length latched at the last fall.
  assign t_last = ovd_q ? CW'(TSO - 1) : CW'(TSN - 1);
  assign t_rst  = ovd_q ? CW'(RST_SLOTS * TSO - 1) : CW'(RST_SLOTS * TSN - 1);
  assign t_pw   = ovd_q ? CW'(PWAIT_SLOTS * TSO - 1) : CW'(PWAIT_SLOTS * TSN - 1);
  assign t_pres = ovd_q ? CW'(PRES_SLOTS * TSO - 1) : CW'(PRES_SLOTS * TSN - 1);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_cnt_d  = bit_cnt_q;
    rx_sh_d    = rx_sh_q;
    tx_sh_d    = tx_sh_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    rx_dat_d   = rx_dat_q;
    owr_e_d    = owr_e_q;
    ovd_d      = ovd_q;
    rxbit_d    = rxbit_q;
    rx_vld_d   = 1'b0;
    rst_det_d  = 1'b0;

    if (tx_vld && !buf_full_q) begin
      buf_d      = tx_dat;
      buf_full_d = 1'b1;
    end

    if (!ena) begin
      state_d   = IDLE;
      owr_e_d   = 1'b0;
      cnt_d     = '0;
      bit_cnt_d = '0;
      rx_sh_d   = '0;
    end else begin
      case (state_q)
        IDLE: if (fall) begin
          ovd_d   = ovd;
          cnt_d   = '0;
          state_d = SLOT;
          // A word starts at bit 0; with nothing buffered the slave only releases.
          if (bit_cnt_q == '0) begin
            tx_sh_d = buf_full_q ? buf_q : '1;
            if (buf_full_q) buf_full_d = 1'b0;
          end
          owr_e_d = ~tx_sh_d[0];
        end
        SLOT: begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == t_last) begin
            rxbit_d = owr_s;
            owr_e_d = 1'b0;
            state_d = HOLD;
          end
        end
        HOLD: begin
          if (owr_s) begin
            rx_sh_d = {rxbit_q, rx_sh_q[BDW-1:1]};
            tx_sh_d = {1'b1, tx_sh_q[BDW-1:1]};
            state_d = IDLE;
            if (bit_cnt_q == BCW'(BDW - 1)) begin
              bit_cnt_d = '0;
              rx_dat_d  = rx_sh_d;
              rx_vld_d  = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + BCW'(1);
            end
          end else if (cnt_q == t_rst) begin
            rst_det_d = 1'b1;
            rx_sh_d   = '0;
            bit_cnt_d = '0;
            state_d   = RSTL;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        RSTL: if (rise) begin
          cnt_d   = '0;
          state_d = PWAIT;
        end
        PWAIT: begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == t_pw) begin
            cnt_d   = '0;
            owr_e_d = 1'b1;
            state_d = PRES;
          end
        end
        PRES: begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == t_pres) begin
            owr_e_d = 1'b0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_cnt_q  <= '0;
      rx_sh_q    <= '0;
      tx_sh_q    <= '1;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      rx_dat_q   <= '0;
      owr_e_q    <= 1'b0;
      ovd_q      <= 1'b0;
      rxbit_q    <= 1'b1;
      rx_vld_q   <= 1'b0;
      rst_det_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_sh_q    <= rx_sh_d;
      tx_sh_q    <= tx_sh_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      rx_dat_q   <= rx_dat_d;
      owr_e_q    <= owr_e_d;
      ovd_q      <= ovd_d;
      rxbit_q    <= rxbit_d;
      rx_vld_q   <= rx_vld_d;
      rst_det_q  <= rst_det_d;
    end
  end

  assign owr_e   = owr_e_q;
  assign tx_rdy  = ~buf_full_q;
  assign rx_dat  = rx_dat_q;
  assign rx_vld  = rx_vld_q;
  assign rst_det = rst_det_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_onewire_slave_sync.sv
// tb/tb_onewire_slave_sync.sv - randomized self-checking bench for onewire_slave_sync
`timescale 1ns/1ps
module tb_onewire_slave_sync;

  localparam int TSN = 30;
  localparam int TSO = 4;
  localparam int BDW = 8;
  localparam int SYN = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           ena = 1'b0;
  logic           ovd = 1'b0;
  logic           m_low = 1'b0;
  logic           owr_i, owr_e, tx_vld = 1'b0, tx_rdy, rx_vld, rst_det, busy;
  logic [BDW-1:0] tx_dat = '0;
  logic [BDW-1:0] rx_dat;

  // Open-drain bus: low if either side pulls.
  assign owr_i = ~(m_low | owr_e);

  onewire_slave_sync #(.TSN(TSN), .TSO(TSO), .BDW(BDW), .SYN(SYN)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ovd     (ovd),
    .owr_i   (owr_i),
    .owr_e   (owr_e),
    .tx_dat  (tx_dat),
    .tx_vld  (tx_vld),
    .tx_rdy  (tx_rdy),
    .rx_dat  (rx_dat),
    .rx_vld  (rx_vld),
    .rst_det (rst_det),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_total = 0;

  int             e_rise[$];
  int             e_width[$];
  int             rst_cyc[$];
  logic [BDW-1:0] rx_got[$];
  logic           e_prev = 1'b0;

  always @(negedge clk) begin
    if (owr_e === 1'b1 && e_prev === 1'b0) e_rise.push_back(cyc);
    if (owr_e === 1'b0 && e_prev === 1'b1) e_width.push_back(cyc - e_rise[$]);
    e_prev = owr_e;
    if (rx_vld === 1'b1) rx_got.push_back(rx_dat);
    if (rst_det === 1'b1) rst_cyc.push_back(cyc);
  end

  function automatic int t_cur();
    return ovd ? TSO : TSN;
  endfunction

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    repeat (SYN + 2) @(negedge clk);
    while ((busy !== 1'b0 || owr_i !== 1'b1) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    n_total++;
    if (n >= 2000) $display("FAIL %s_idle: busy=%b owr_i=%b, required busy=0 owr_i=1", tag, busy, owr_i);
    else n_pass++;
    repeat (2) @(negedge clk);
  endtask

  task automatic slot(input int low, output int f);
    @(negedge clk);
    f = cyc;
    m_low = 1'b1;
    repeat (low) @(negedge clk);
    m_low = 1'b0;
    wait_idle("slot");
  endtask

  task automatic reset_pulse(input int low, output int f, output int r);
    @(negedge clk);
    f = cyc;
    m_low = 1'b1;
    repeat (low) @(negedge clk);
    r = cyc;
    m_low = 1'b0;
    wait_idle("reset");
  endtask

  task automatic write_bits(input logic [BDW-1:0] b, input int nbits);
    int t, low, f;
    t = t_cur();
    for (int i = 0; i < nbits; i++) begin
      if (b[i]) low = $urandom_range(1, (t / 5 > 1) ? t / 5 : 1);
      else      low = $urandom_range(t + 2, 2 * t);
      slot(low, f);
    end
  endtask

  task automatic tx_push(input logic [BDW-1:0] b);
    @(negedge clk);
    n_total++;
    if (tx_rdy !== 1'b1) $display("FAIL push_rdy_before: tx_rdy=%b, required 1", tx_rdy);
    else n_pass++;
    tx_dat = b;
    tx_vld = 1'b1;
    @(negedge clk);
    tx_vld = 1'b0;
    n_total++;
    if (tx_rdy !== 1'b0) $display("FAIL push_rdy_after: tx_rdy=%b, required 0", tx_rdy);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ena = 1'b1;
    repeat (3) @(negedge clk);
    n_total++;
    if ({owr_e, tx_rdy, rx_vld, rst_det, busy} !== 5'b01000)
      $display("FAIL reset_flags: owr_e,tx_rdy,rx_vld,rst_det,busy=%b, required 01000",
               {owr_e, tx_rdy, rx_vld, rst_det, busy});
    else n_pass++;
    n_total++;
    if (rx_dat !== '0) $display("FAIL reset_rx_dat: rx_dat=%h, required 00", rx_dat);
    else n_pass++;
    rst_n = 1'b1;
    repeat (SYN + 2) @(negedge clk);
  endtask

  task automatic test_presence(input int low);
    int t, nr, ne, f, r;
    t  = t_cur();
    nr = rst_cyc.size();
    ne = e_rise.size();
    reset_pulse(low, f, r);
    n_total++;
    if (rst_cyc.size() != nr + 1) $display("FAIL pres_rst_count: got %0d, required %0d", rst_cyc.size() - nr, 1);
    else n_pass++;
    n_total++;
    if (rst_cyc[$] != f + 8 * t + SYN + 1)
      $display("FAIL pres_rst_time: got %0d, required %0d", rst_cyc[$] - f, 8 * t + SYN + 1);
    else n_pass++;
    n_total++;
    if (e_rise.size() != ne + 1) $display("FAIL pres_pulse_count: got %0d, required 1", e_rise.size() - ne);
    else n_pass++;
    n_total++;
    if (e_rise[$] != r + SYN + 1 + t)
      $display("FAIL pres_start: got %0d, required %0d", e_rise[$] - r, SYN + 1 + t);
    else n_pass++;
    n_total++;
    if (e_width[$] != 4 * t) $display("FAIL pres_width: got %0d, required %0d", e_width[$], 4 * t);
    else n_pass++;
  endtask

  task automatic check_write(input logic [BDW-1:0] b);
    int nr, ne;
    nr = rx_got.size();
    ne = e_rise.size();
    write_bits(b, BDW);
    n_total++;
    if (rx_got.size() != nr + 1) $display("FAIL wr_vld_count: got %0d, required 1", rx_got.size() - nr);
    else n_pass++;
    n_total++;
    if (rx_got[$] !== b) $display("FAIL wr_data: got %h, required %h", rx_got[$], b);
    else n_pass++;
    n_total++;
    if (e_rise.size() != ne) $display("FAIL wr_owr_e: got %0d pulses, required 0", e_rise.size() - ne);
    else n_pass++;
  endtask

  task automatic test_write();
    ovd = 1'b0;
    check_write(8'hA5);
    check_write(8'($urandom));
  endtask

  task automatic check_read(input logic [BDW-1:0] b);
    int ne, f;
    tx_push(b);
    for (int i = 0; i < BDW; i++) begin
      ne = e_rise.size();
      slot(2, f);
      if (b[i] == 1'b0) begin
        n_total++;
        if (e_rise.size() != ne + 1 || e_rise[$] != f + SYN + 1 || e_width[$] != TSN)
          $display("FAIL rd_bit%0d: pulses=%0d start=%0d width=%0d, required 1/%0d/%0d",
                   i, e_rise.size() - ne, e_rise[$] - f, e_width[$], SYN + 1, TSN);
        else n_pass++;
      end else begin
        n_total++;
        if (e_rise.size() != ne) $display("FAIL rd_bit%0d: pulses=%0d, required 0", i, e_rise.size() - ne);
        else n_pass++;
      end
      if (i == 0) begin
        n_total++;
        if (tx_rdy !== 1'b1) $display("FAIL rd_tx_rdy: tx_rdy=%b, required 1", tx_rdy);
        else n_pass++;
      end
    end
    n_total++;
    if (rx_got[$] !== b) $display("FAIL rd_rx_echo: got %h, required %h", rx_got[$], b);
    else n_pass++;
  endtask

  task automatic test_read();
    ovd = 1'b0;
    check_read(8'h3C);
    check_read(8'($urandom));
  endtask

  task automatic test_overdrive();
    @(negedge clk);
    ovd = 1'b1;
    test_presence(12 * TSO);
    check_write(8'hFF);
    check_write(8'h00);
    check_write(8'($urandom));
    @(negedge clk);
    ovd = 1'b0;
  endtask

  task automatic test_abort();
    int nr, ns, f, r;
    nr = rx_got.size();
    ns = rst_cyc.size();
    write_bits(8'($urandom), 3);
    reset_pulse(16 * TSN, f, r);
    n_total++;
    if (rst_cyc.size() != ns + 1 || rx_got.size() != nr)
      $display("FAIL abort_discard: rst_det=%0d rx_vld=%0d, required 1/0", rst_cyc.size() - ns, rx_got.size() - nr);
    else n_pass++;
    check_write(8'h5A);
  endtask

  task automatic test_async_reset();
    int n, f, ne, nr;
    logic [BDW-1:0] b;
    b = 8'($urandom) & 8'hFE;
    tx_push(b);
    @(negedge clk);
    f = cyc;
    m_low = 1'b1;
    repeat (2) @(negedge clk);
    m_low = 1'b0;
    n = 0;
    while (owr_e !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    n_total++;
    if (n >= 50) $display("FAIL ares_drive: owr_e=%b, required 1", owr_e);
    else n_pass++;
    #3 rst_n = 1'b0;
    #1;
    n_total++;
    if ({owr_e, tx_rdy, rx_vld, rst_det, busy} !== 5'b01000 || rx_dat !== '0)
      $display("FAIL ares_outputs: flags=%b rx_dat=%h, required 01000/00",
               {owr_e, tx_rdy, rx_vld, rst_det, busy}, rx_dat);
    else n_pass++;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (SYN + 2) @(negedge clk);
    ne = e_rise.size();
    nr = rx_got.size();
    for (int i = 0; i < BDW; i++) slot(2, f);
    n_total++;
    if (e_rise.size() != ne) $display("FAIL ares_released: pulses=%0d, required 0", e_rise.size() - ne);
    else n_pass++;
    n_total++;
    if (rx_got.size() != nr + 1 || rx_got[$] !== '1)
      $display("FAIL ares_rx: count=%0d data=%h, required 1/ff", rx_got.size() - nr, rx_got[$]);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_presence(16 * TSN);
    test_write();
    test_read();
    test_overdrive();
    test_abort();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
